// File: rtl/cnn_pkg.sv
//==============================================================================
// Module : cnn_pkg
// Brief  : Shared widths, map geometry and saturation limit for the CNN
//          post-accumulation stage.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package cnn_pkg;

  localparam int ACI_BW   = 21;
  localparam int B_BW     = 16;
  localparam int O_F_BW   = 8;
  localparam int SHIFT    = 7;
  localparam int IN_X     = 24;
  localparam int IN_Y     = 24;

  localparam int FMAP_MAX = (2 ** O_F_BW) - 1;
  localparam int OUT_X    = IN_X / 2;
  localparam int OUT_Y    = IN_Y / 2;

endpackage

`default_nettype wire

// File: rtl/cnn_relu_pool_if.sv
//==============================================================================
// Module : cnn_relu_pool_if
// Brief  : Accumulator-in / pooled-pixel-out bundle for cnn_relu_pool.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface cnn_relu_pool_if #(
  parameter int ACI_BW = cnn_pkg::ACI_BW,
  parameter int B_BW   = cnn_pkg::B_BW,
  parameter int O_F_BW = cnn_pkg::O_F_BW
);

  logic signed [B_BW-1:0]   i_bias;
  logic                     i_in_valid;
  logic signed [ACI_BW-1:0] i_ci_acc;
  logic                     o_ot_valid;
  logic [O_F_BW-1:0]        o_ot_fmap;
  logic                     o_frame_done;

  modport master (
    output i_bias, i_in_valid, i_ci_acc,
    input  o_ot_valid, o_ot_fmap, o_frame_done
  );

  modport slave (
    input  i_bias, i_in_valid, i_ci_acc,
    output o_ot_valid, o_ot_fmap, o_frame_done
  );

endinterface

`default_nettype wire

// File: rtl/cnn_requant.sv
//==============================================================================
// Module : cnn_requant
// Brief  : Input capture, bias add, ReLU, arithmetic shift and saturation to
//          an unsigned feature byte, with a valid carried alongside the data.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module cnn_requant #(
  parameter int ACI_BW = cnn_pkg::ACI_BW,
  parameter int B_BW   = cnn_pkg::B_BW,
  parameter int O_F_BW = cnn_pkg::O_F_BW,
  parameter int SHIFT  = cnn_pkg::SHIFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic signed [ACI_BW-1:0] i_acc,
  input  logic signed [B_BW-1:0]   i_bias,
  output logic                     o_valid,
  output logic [O_F_BW-1:0]        o_q
);

  import cnn_pkg::*;

  localparam int c_sum_bw = ((ACI_BW > B_BW) ? ACI_BW : B_BW) + 1;

  if (O_F_BW >= c_sum_bw) begin : g_chk_out_bw
    $error("cnn_requant: O_F_BW must be narrower than the bias-add sum");
  end

  logic                       r_in_valid;
  logic signed [ACI_BW-1:0]   r_acc;
  logic                       r_sum_valid;
  logic signed [c_sum_bw-1:0] r_sum;
  logic                       r_q_valid;
  logic [O_F_BW-1:0]          r_q;
  logic signed [c_sum_bw-1:0] w_shifted;
  logic [O_F_BW-1:0]          w_q;

  // Input capture isolates the accumulator's output timing from the adder.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_valid  <= 1'b0;
      r_acc       <= '0;
      r_sum_valid <= 1'b0;
      r_sum       <= '0;
      r_q_valid   <= 1'b0;
      r_q         <= '0;
    end else begin
      r_in_valid  <= i_valid;
      if (i_valid) r_acc <= i_acc;
      r_sum_valid <= r_in_valid;
      if (r_in_valid) r_sum <= c_sum_bw'(r_acc) + c_sum_bw'(i_bias);
      r_q_valid   <= r_sum_valid;
      if (r_sum_valid) r_q <= w_q;
    end
  end

  always_comb begin
    w_shifted = r_sum >>> SHIFT;
    w_q       = w_shifted[O_F_BW-1:0];
    if (r_sum[c_sum_bw-1]) begin
      w_q = '0;
    end else if (|w_shifted[c_sum_bw-1:O_F_BW]) begin
      w_q = '1;
    end
  end

  assign o_valid = r_q_valid;
  assign o_q     = r_q;

endmodule

`default_nettype wire

// File: rtl/cnn_relu_pool.sv
//==============================================================================
// Module : cnn_relu_pool
// Brief  : Bias/ReLU/requant followed by 2x2 stride-2 max pooling over one
//          raster-ordered feature map.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module cnn_relu_pool #(
  parameter int ACI_BW = cnn_pkg::ACI_BW,
  parameter int B_BW   = cnn_pkg::B_BW,
  parameter int O_F_BW = cnn_pkg::O_F_BW,
  parameter int SHIFT  = cnn_pkg::SHIFT,
  parameter int IN_X   = cnn_pkg::IN_X,
  parameter int IN_Y   = cnn_pkg::IN_Y
) (
  input  logic           clk,
  input  logic           reset,
  cnn_relu_pool_if.slave bus
);

  import cnn_pkg::*;

  localparam int c_x_bw  = $clog2(IN_X);
  localparam int c_y_bw  = $clog2(IN_Y);
  localparam int c_lb_n  = IN_X / 2;
  localparam int c_lb_aw = (c_lb_n > 1) ? $clog2(c_lb_n) : 1;
  localparam logic [c_x_bw-1:0] c_x_last = c_x_bw'(IN_X - 1);
  localparam logic [c_y_bw-1:0] c_y_last = c_y_bw'(IN_Y - 1);

  if ((IN_X % 2) != 0 || IN_X < 2) begin : g_chk_in_x
    $error("cnn_relu_pool: IN_X must be even and non-zero");
  end
  if ((IN_Y % 2) != 0 || IN_Y < 2) begin : g_chk_in_y
    $error("cnn_relu_pool: IN_Y must be even and non-zero");
  end
  if (SHIFT >= ACI_BW) begin : g_chk_shift
    $error("cnn_relu_pool: SHIFT must be smaller than ACI_BW");
  end

  logic                w_q_valid;
  logic [O_F_BW-1:0]   w_q;
  logic [c_x_bw-1:0]   r_x;
  logic [c_y_bw-1:0]   r_y;
  logic [O_F_BW-1:0]   r_hold;
  logic [O_F_BW-1:0]   r_lbuf [c_lb_n];
  logic [c_lb_aw-1:0]  w_lidx;
  logic [O_F_BW-1:0]   w_above;
  logic [O_F_BW-1:0]   w_m;
  logic [O_F_BW-1:0]   w_pool;
  logic                w_last_x;
  logic                w_last_y;
  logic                r_ot_valid;
  logic [O_F_BW-1:0]   r_fmap;
  logic                r_frame_done;

  cnn_requant #(
    .ACI_BW (ACI_BW),
    .B_BW   (B_BW),
    .O_F_BW (O_F_BW),
    .SHIFT  (SHIFT)
  ) u_requant (
    .clk     (clk),
    .reset   (reset),
    .i_valid (bus.i_in_valid),
    .i_acc   (bus.i_ci_acc),
    .i_bias  (bus.i_bias),
    .o_valid (w_q_valid),
    .o_q     (w_q)
  );

  always_comb begin
    w_lidx   = c_lb_aw'(r_x >> 1);
    w_above  = r_lbuf[w_lidx];
    w_m      = (r_hold > w_q) ? r_hold : w_q;
    w_pool   = (w_above > w_m) ? w_above : w_m;
    w_last_x = (r_x == c_x_last);
    w_last_y = (r_y == c_y_last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_hold       <= '0;
      r_ot_valid   <= 1'b0;
      r_fmap       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_ot_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_q_valid) begin
        if (!r_x[0]) begin
          r_hold <= w_q;
        end else if (r_y[0]) begin
          r_fmap       <= w_pool;
          r_ot_valid   <= 1'b1;
          r_frame_done <= w_last_x && w_last_y;
        end
        if (w_last_x) begin
          r_x <= '0;
          r_y <= w_last_y ? '0 : r_y + c_y_bw'(1);
        end else begin
          r_x <= r_x + c_x_bw'(1);
        end
      end
    end
  end

  // Every entry is rewritten in an even row before the odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_q_valid && r_x[0] && !r_y[0]) begin
      r_lbuf[w_lidx] <= w_m;
    end
  end

  assign bus.o_ot_valid   = r_ot_valid;
  assign bus.o_ot_fmap    = r_fmap;
  assign bus.o_frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_cnn_relu_pool.sv
//==============================================================================
// Module : tb_cnn_relu_pool
// Brief  : Directed bench for cnn_relu_pool at default geometry and at 4x4.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cnn_relu_pool;

  import cnn_pkg::*;

  localparam int S_X     = 4;
  localparam int S_Y     = 4;
  localparam int S_SHIFT = 0;
  localparam int NPIX    = (IN_X / 2) * (IN_Y / 2);

  typedef struct { int acc; int bias; int want; } vec_t;
  typedef struct { int v; bit done; int cyc; } out_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   stray_d = 0;
  int   stray_s = 0;
  out_t oq_d[$];
  out_t oq_s[$];

  vec_t tbl[12];
  int   pool_ramp[16];
  int   pool_pat[16];
  int   want_ramp[4];
  int   want_pat[4];

  cnn_relu_pool_if #(.ACI_BW(ACI_BW), .B_BW(B_BW), .O_F_BW(O_F_BW)) bus_d ();
  cnn_relu_pool_if #(.ACI_BW(ACI_BW), .B_BW(B_BW), .O_F_BW(O_F_BW)) bus_s ();

  cnn_relu_pool #(
    .ACI_BW(ACI_BW), .B_BW(B_BW), .O_F_BW(O_F_BW),
    .SHIFT(SHIFT), .IN_X(IN_X), .IN_Y(IN_Y)
  ) dut_d (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_d)
  );

  cnn_relu_pool #(
    .ACI_BW(ACI_BW), .B_BW(B_BW), .O_F_BW(O_F_BW),
    .SHIFT(S_SHIFT), .IN_X(S_X), .IN_Y(S_Y)
  ) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_d.o_ot_valid === 1'b1)
      oq_d.push_back('{v: int'(bus_d.o_ot_fmap), done: bus_d.o_frame_done, cyc: cyc});
    if (bus_s.o_ot_valid === 1'b1)
      oq_s.push_back('{v: int'(bus_s.o_ot_fmap), done: bus_s.o_frame_done, cyc: cyc});
    if (bus_d.o_frame_done === 1'b1 && bus_d.o_ot_valid !== 1'b1) stray_d <= stray_d + 1;
    if (bus_s.o_frame_done === 1'b1 && bus_s.o_ot_valid !== 1'b1) stray_s <= stray_s + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic drive_d(input bit v, input int acc, input int bias);
    @(negedge clk);
    bus_d.i_in_valid = v;
    bus_d.i_ci_acc   = ACI_BW'(acc);
    bus_d.i_bias     = B_BW'(bias);
  endtask

  task automatic drive_s(input bit v, input int acc);
    @(negedge clk);
    bus_s.i_in_valid = v;
    bus_s.i_ci_acc   = ACI_BW'(acc);
    bus_s.i_bias     = '0;
  endtask

  task automatic check_frames_d(input string name, input int nframes, input int want);
    int nwrong = 0;
    int ndone = 0;
    int ndone_bad = 0;
    foreach (oq_d[i]) begin
      if (oq_d[i].v != want) nwrong++;
      if (oq_d[i].done) ndone++;
      if (oq_d[i].done != (((i + 1) % NPIX) == 0)) ndone_bad++;
    end
    check({name, " pulse count"}, oq_d.size(), nframes * NPIX);
    check({name, " first pixel"}, (oq_d.size() > 0) ? oq_d[0].v : -1, want);
    check({name, " wrong pixels"}, nwrong, 0);
    check({name, " frame_done count"}, ndone, nframes);
    check({name, " frame_done misplaced"}, ndone_bad, 0);
    check({name, " frame_done without valid"}, stray_d, 0);
  endtask

  // Windows complete at raster indices 5, 7, 13, 15 of a 4x4 map.
  task automatic run_small(input string name, input int vals[16], input int want[4], input int maxgap);
    int samp[16];
    int cidx[4] = '{5, 7, 13, 15};
    oq_s.delete();
    for (int i = 0; i < 16; i++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (gap) drive_s(1'b0, 0);
      drive_s(1'b1, vals[i]);
      samp[i] = cyc + 1;
    end
    drive_s(1'b0, 0);
    repeat (8) @(negedge clk);
    check({name, " pulse count"}, oq_s.size(), 4);
    for (int j = 0; j < 4 && j < oq_s.size(); j++) begin
      check($sformatf("%s value[%0d]", name, j), oq_s[j].v, want[j]);
      check($sformatf("%s latency[%0d]", name, j), oq_s[j].cyc - samp[cidx[j]], 3);
      check($sformatf("%s frame_done[%0d]", name, j), oq_s[j].done, (j == 3) ? 1 : 0);
    end
    check({name, " frame_done without valid"}, stray_s, 0);
  endtask

  initial begin
    tbl[0]  = '{1000,      0,     7};
    tbl[1]  = '{-500,      100,   0};
    tbl[2]  = '{40000,     0,     255};
    tbl[3]  = '{0,         1280,  10};
    tbl[4]  = '{127,       0,     0};
    tbl[5]  = '{128,       0,     1};
    tbl[6]  = '{32767,     0,     255};
    tbl[7]  = '{32768,     0,     255};
    tbl[8]  = '{1000,      -872,  1};
    tbl[9]  = '{1048575,   32767, 255};
    tbl[10] = '{-1048576, -32768, 0};
    tbl[11] = '{-1,        1,     0};

    for (int i = 0; i < 16; i++) pool_ramp[i] = i;
    want_ramp = '{5, 7, 13, 15};
    pool_pat  = '{1, 9, 2, 3,
                  4, 5, 6, 300,
                  7, 8, 50, 11,
                  60, -7, 3, 4};
    want_pat  = '{9, 255, 60, 50};

    bus_d.i_in_valid = 1'b0; bus_d.i_ci_acc = '0; bus_d.i_bias = '0;
    bus_s.i_in_valid = 1'b0; bus_s.i_ci_acc = '0; bus_s.i_bias = '0;

    // Random traffic under reset, with valid forced high on the final cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset            = 1'b1;
      bus_d.i_in_valid = (i == 2) ? 1'b1 : 1'($urandom);
      bus_d.i_ci_acc   = ACI_BW'($urandom);
      bus_d.i_bias     = B_BW'($urandom);
      bus_s.i_in_valid = (i == 2) ? 1'b1 : 1'($urandom);
      bus_s.i_ci_acc   = ACI_BW'($urandom);
      @(posedge clk);
      #1;
      check($sformatf("reset ot_valid d[%0d]", i), bus_d.o_ot_valid, 0);
      check($sformatf("reset ot_fmap d[%0d]", i), bus_d.o_ot_fmap, 0);
      check($sformatf("reset frame_done d[%0d]", i), bus_d.o_frame_done, 0);
      check($sformatf("reset ot_valid s[%0d]", i), bus_s.o_ot_valid, 0);
      check($sformatf("reset ot_fmap s[%0d]", i), bus_s.o_ot_fmap, 0);
      check($sformatf("reset frame_done s[%0d]", i), bus_s.o_frame_done, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    bus_d.i_in_valid = 1'b0;
    bus_s.i_in_valid = 1'b0;
    bus_d.i_bias     = '0;
    repeat (6) @(negedge clk);
    check("no output after reset d", oq_d.size(), 0);
    check("no output after reset s", oq_s.size(), 0);

    run_small("ramp", pool_ramp, want_ramp, 0);
    run_small("pattern", pool_pat, want_pat, 0);
    run_small("ramp gapped", pool_ramp, want_ramp, 5);
    run_small("pattern gapped", pool_pat, want_pat, 5);

    for (int r = 0; r < 12; r++) begin
      oq_d.delete();
      for (int i = 0; i < IN_X * IN_Y; i++) drive_d(1'b1, tbl[r].acc, tbl[r].bias);
      drive_d(1'b0, 0, tbl[r].bias);
      repeat (8) @(negedge clk);
      check_frames_d($sformatf("frame row%0d acc=%0d bias=%0d", r, tbl[r].acc, tbl[r].bias),
                     1, tbl[r].want);
    end

    // Saturated data partly fills the line buffer, then reset lands mid-frame.
    for (int i = 0; i < 30; i++) drive_d(1'b1, 40000, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_d.i_in_valid = 1'b0;
    @(negedge clk);
    oq_d.delete();
    for (int i = 0; i < 2 * IN_X * IN_Y; i++) drive_d(1'b1, 1000, 0);
    drive_d(1'b0, 0, 0);
    repeat (8) @(negedge clk);
    check_frames_d("back-to-back after reset", 2, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
